// File: rtl/pulpino_boot_seq.sv
// Boot and watchdog sequencer for the PULPino SoC: stretches the SoC reset, delays
// and gates instruction fetch, and re-resets the SoC when the software heartbeat stops.
module pulpino_boot_seq #(
  parameter int unsigned RST_HOLD_CYCLES = 16,
  parameter int unsigned FETCH_DELAY     = 8,
  parameter int unsigned WDT_TIMEOUT     = 2**20,
  parameter int unsigned SYNC_STAGES     = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ext_fetch_en_i,
  input  logic       heartbeat_i,
  input  logic       wdt_en_i,
  output logic       soc_rst_no,
  output logic       fetch_enable_o,
  output logic       wdt_expired_o,
  output logic [3:0] reset_count_o
);

  localparam int unsigned MAX_HD  = (RST_HOLD_CYCLES > FETCH_DELAY) ? RST_HOLD_CYCLES : FETCH_DELAY;
  localparam int unsigned MAX_ALL = (MAX_HD > WDT_TIMEOUT) ? MAX_HD : WDT_TIMEOUT;
  localparam int unsigned CW      = $clog2(MAX_ALL + 1);

  localparam logic [CW-1:0] HOLD_LAST  = CW'(RST_HOLD_CYCLES - 1);
  localparam logic [CW-1:0] DELAY_LAST = CW'(FETCH_DELAY - 1);
  localparam logic [CW-1:0] WDT_LAST   = CW'(WDT_TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_HOLD  = 2'd0,
    S_DELAY = 2'd1,
    S_ARMED = 2'd2,
    S_RUN   = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            expired_q, expired_d;
  logic [3:0]      rcount_q, rcount_d;
  logic            soc_rst_q, fetch_q;

  logic [SYNC_STAGES-1:0] fe_sync_q, hb_sync_q, wdt_sync_q;
  logic                   hb_dly_q;
  logic                   fe_s, hb_s, wdt_s, hb_edge;

  // Input synchronizers; every stage clears with rst_n.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fe_sync_q  <= '0;
      hb_sync_q  <= '0;
      wdt_sync_q <= '0;
      hb_dly_q   <= 1'b0;
    end else begin
      fe_sync_q  <= {fe_sync_q[SYNC_STAGES-2:0],  ext_fetch_en_i};
      hb_sync_q  <= {hb_sync_q[SYNC_STAGES-2:0],  heartbeat_i};
      wdt_sync_q <= {wdt_sync_q[SYNC_STAGES-2:0], wdt_en_i};
      hb_dly_q   <= hb_s;
    end
  end

  assign fe_s    = fe_sync_q[SYNC_STAGES-1];
  assign hb_s    = hb_sync_q[SYNC_STAGES-1];
  assign wdt_s   = wdt_sync_q[SYNC_STAGES-1];
  assign hb_edge = hb_s ^ hb_dly_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_HOLD;
      cnt_q     <= '0;
      expired_q <= 1'b0;
      rcount_q  <= '0;
      soc_rst_q <= 1'b0;
      fetch_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      expired_q <= expired_d;
      rcount_q  <= rcount_d;
      soc_rst_q <= (state_d != S_HOLD);
      fetch_q   <= (state_d == S_RUN);
    end
  end

  // Fetch withdrawal outranks the watchdog; a heartbeat edge outranks expiry.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    expired_d = expired_q;
    rcount_d  = rcount_q;
    case (state_q)
      S_HOLD: begin
        if (cnt_q == HOLD_LAST) begin
          state_d = S_DELAY;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DELAY: begin
        if (cnt_q == DELAY_LAST) begin
          state_d = S_ARMED;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_ARMED: begin
        if (fe_s) begin
          state_d = S_RUN;
          cnt_d   = '0;
        end
      end
      S_RUN: begin
        if (!fe_s) begin
          state_d = S_ARMED;
          cnt_d   = '0;
        end else if (!wdt_s || hb_edge) begin
          cnt_d = '0;
        end else if (cnt_q == WDT_LAST) begin
          state_d   = S_HOLD;
          cnt_d     = '0;
          expired_d = 1'b1;
          if (rcount_q != 4'hF) rcount_d = rcount_q + 4'd1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = S_HOLD;
        cnt_d   = '0;
      end
    endcase
  end

  assign soc_rst_no     = soc_rst_q;
  assign fetch_enable_o = fetch_q;
  assign wdt_expired_o  = expired_q;
  assign reset_count_o  = rcount_q;

endmodule

// File: tb/tb_pulpino_boot_seq.sv
// Directed bench for pulpino_boot_seq: power-on table plus watchdog, fetch and reset sequences.
module tb_pulpino_boot_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ext_fetch_en_i;
  logic       heartbeat_i;
  logic       wdt_en_i;
  logic       soc_rst_no;
  logic       fetch_enable_o;
  logic       wdt_expired_o;
  logic [3:0] reset_count_o;

  int tests = 0;
  int fails = 0;
  int edge_n = 0;

  typedef struct {
    int       e;
    logic     rst;
    logic     fe;
    logic     exp;
    logic [3:0] cnt;
  } vec_t;

  vec_t pon[6];

  pulpino_boot_seq #(
    .RST_HOLD_CYCLES(16),
    .FETCH_DELAY(8),
    .WDT_TIMEOUT(64),
    .SYNC_STAGES(2)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .ext_fetch_en_i(ext_fetch_en_i),
    .heartbeat_i(heartbeat_i),
    .wdt_en_i(wdt_en_i),
    .soc_rst_no(soc_rst_no),
    .fetch_enable_o(fetch_enable_o),
    .wdt_expired_o(wdt_expired_o),
    .reset_count_o(reset_count_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int got, input int exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s at edge %0d: got %0d, expected %0d", name, edge_n, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    edge_n++;
  endtask

  task automatic run_to(input int target);
    while (edge_n < target) step();
  endtask

  task automatic check_all(input string tag, input logic r, input logic f, input logic x, input logic [3:0] c);
    check({tag, ".soc_rst_no"},     int'(soc_rst_no),     int'(r));
    check({tag, ".fetch_enable_o"}, int'(fetch_enable_o), int'(f));
    check({tag, ".wdt_expired_o"},  int'(wdt_expired_o),  int'(x));
    check({tag, ".reset_count_o"},  int'(reset_count_o),  int'(c));
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst_n  = 1'b1;
    edge_n = 0;
  endtask

  task automatic run_poweron_table(input string tag);
    for (int i = 0; i < 6; i++) begin
      run_to(pon[i].e);
      check_all(tag, pon[i].rst, pon[i].fe, pon[i].exp, pon[i].cnt);
    end
  endtask

  initial begin
    int x_edge, y_edge, w_edge, z_edge, bound;
    bit ok_rst, ok_fe;
    int exp_cnt;

    pon[0] = '{e: 1,  rst: 1'b0, fe: 1'b0, exp: 1'b0, cnt: 4'd0};
    pon[1] = '{e: 15, rst: 1'b0, fe: 1'b0, exp: 1'b0, cnt: 4'd0};
    pon[2] = '{e: 16, rst: 1'b1, fe: 1'b0, exp: 1'b0, cnt: 4'd0};
    pon[3] = '{e: 24, rst: 1'b1, fe: 1'b0, exp: 1'b0, cnt: 4'd0};
    pon[4] = '{e: 25, rst: 1'b1, fe: 1'b1, exp: 1'b0, cnt: 4'd0};
    pon[5] = '{e: 30, rst: 1'b1, fe: 1'b1, exp: 1'b0, cnt: 4'd0};

    rst_n = 1'b0; ext_fetch_en_i = 1'b1; heartbeat_i = 1'b0; wdt_en_i = 1'b0;
    #23;
    check_all("reset", 1'b0, 1'b0, 1'b0, 4'd0);
    release_reset();
    run_poweron_table("poweron");

    // Watchdog expiry: wdt_s rises after edge 32, counting from edge 33.
    wdt_en_i = 1'b1;
    run_to(95);  check("wdt_pre.soc_rst_no", int'(soc_rst_no), 1);
    run_to(96);  check_all("wdt_exp", 1'b0, 1'b0, 1'b1, 4'd1);
    run_to(111); check("wdt_hold.soc_rst_no", int'(soc_rst_no), 0);
    run_to(112); check("wdt_rel.soc_rst_no", int'(soc_rst_no), 1);
    run_to(120); check("wdt_armed.fetch", int'(fetch_enable_o), 0);
    run_to(121); check("wdt_run.fetch", int'(fetch_enable_o), 1);

    // Keep-alive: toggle every 50 cycles for 10000 cycles.
    ok_rst = 1'b1;
    for (int i = 0; i < 200; i++) begin
      heartbeat_i = ~heartbeat_i;
      for (int j = 0; j < 50; j++) begin
        step();
        if (soc_rst_no !== 1'b1) ok_rst = 1'b0;
      end
    end
    check("keepalive.no_reset", int'(ok_rst), 1);

    // Second toggle's edge lands exactly in the expiry cycle of the first.
    x_edge = edge_n;
    heartbeat_i = ~heartbeat_i;
    run_to(x_edge + 64);
    y_edge = edge_n;
    heartbeat_i = ~heartbeat_i;
    run_to(x_edge + 67); check("hb_expiry_cycle.soc_rst_no", int'(soc_rst_no), 1);
    run_to(y_edge + 66); check("hb_late.soc_rst_no", int'(soc_rst_no), 1);
    run_to(y_edge + 67); check_all("hb_late_exp", 1'b0, 1'b0, 1'b1, 4'd2);
    run_to(y_edge + 91); check("rerun_armed.fetch", int'(fetch_enable_o), 0);
    run_to(y_edge + 92); check("rerun.fetch", int'(fetch_enable_o), 1);

    // Fetch withdrawal in RUN.
    w_edge = edge_n;
    ext_fetch_en_i = 1'b0;
    run_to(w_edge + 2); check("withdraw_pre.fetch", int'(fetch_enable_o), 1);
    run_to(w_edge + 3); check("withdraw.fetch", int'(fetch_enable_o), 0);
    run_to(w_edge + 10); check("withdraw.soc_rst_no", int'(soc_rst_no), 1);
    check("withdraw.count", int'(reset_count_o), 2);

    // Re-request with the watchdog disabled; idle heartbeat for 1000 cycles.
    z_edge = edge_n;
    ext_fetch_en_i = 1'b1;
    wdt_en_i = 1'b0;
    run_to(z_edge + 2); check("refetch_pre.fetch", int'(fetch_enable_o), 0);
    run_to(z_edge + 3); check("refetch.fetch", int'(fetch_enable_o), 1);
    ok_rst = 1'b1; ok_fe = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      step();
      if (soc_rst_no !== 1'b1) ok_rst = 1'b0;
      if (fetch_enable_o !== 1'b1) ok_fe = 1'b0;
    end
    check("wdt_off.no_reset", int'(ok_rst), 1);
    check("wdt_off.fetch_held", int'(ok_fe), 1);

    // Saturation over 17 further expiries.
    wdt_en_i = 1'b1;
    exp_cnt = 2;
    for (int k = 0; k < 17; k++) begin
      bound = 0;
      while (soc_rst_no !== 1'b0 && bound < 300) begin step(); bound++; end
      check("sat.fall_seen", int'(soc_rst_no), 0);
      if (exp_cnt < 15) exp_cnt++;
      check("sat.count", int'(reset_count_o), exp_cnt);
      check("sat.expired", int'(wdt_expired_o), 1);
      if (k < 16) begin
        bound = 0;
        while (soc_rst_no !== 1'b1 && bound < 40) begin step(); bound++; end
        check("sat.rise_seen", int'(soc_rst_no), 1);
      end
    end
    check("sat.final_count", int'(reset_count_o), 15);

    // Abort mid-HOLD: outputs clear at once, power-on timing repeats.
    run_to(edge_n + 5);
    wdt_en_i = 1'b0;
    #2 rst_n = 1'b0;
    #1 check_all("abort", 1'b0, 1'b0, 1'b0, 4'd0);
    release_reset();
    run_poweron_table("abort_poweron");

    // Deferred fetch: request held low through edge 40.
    rst_n = 1'b0;
    ext_fetch_en_i = 1'b0;
    #3 check_all("defer_reset", 1'b0, 1'b0, 1'b0, 4'd0);
    release_reset();
    run_to(16); check("defer.soc_rst_no", int'(soc_rst_no), 1);
    ok_rst = 1'b1; ok_fe = 1'b1;
    while (edge_n < 40) begin
      step();
      if (soc_rst_no !== 1'b1) ok_rst = 1'b0;
      if (fetch_enable_o !== 1'b0) ok_fe = 1'b0;
    end
    check("defer.fetch_low", int'(ok_fe), 1);
    ext_fetch_en_i = 1'b1;
    run_to(42); check("defer_pre.fetch", int'(fetch_enable_o), 0);
    if (soc_rst_no !== 1'b1) ok_rst = 1'b0;
    run_to(43); check("defer.fetch", int'(fetch_enable_o), 1);
    if (soc_rst_no !== 1'b1) ok_rst = 1'b0;
    check("defer.rst_held", int'(ok_rst), 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
